cpu_trace_checker: RTL and testbench

CPU_TRACE_CHECKER -- requirements
Module: cpu_trace_checker

---
 rtl/cpu_trace_checker.sv | 238 +++++++++++++++++++++++
 tb/tb_cpu_trace_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_checker.sv
// Streaming checker for CPU write-trace lines of the form "^time@pc: $reg|*addr <= data#".
// Semantic error checking is compiled in only when CPU_TRACE_CHECK_ERR_EN is defined.
module cpu_trace_checker #(
  parameter int unsigned TIME_DIG = 4,
  parameter int unsigned REG_DIG  = 4,
  parameter int unsigned HEX_DIG  = 8,
  parameter logic [31:0] PC_LO    = 32'h3000,
  parameter logic [31:0] PC_HI    = 32'h4fff,
  parameter logic [31:0] ADDR_HI  = 32'h2fff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code,
  output logic [15:0] line_count
);

  localparam int unsigned TW   = 4 * TIME_DIG;
  localparam int unsigned RW   = 4 * REG_DIG;
  localparam int unsigned HW   = 4 * HEX_DIG;
  localparam int unsigned M1   = (TW > RW) ? TW : RW;
  localparam int unsigned M2   = (M1 > HW) ? M1 : HW;
  localparam int unsigned XW   = (M2 > 32) ? M2 : 32;
  localparam int unsigned CMAX = M2 / 4;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_COLON, S_SEL, S_REG, S_ADDR, S_LT, S_EQ, S_DATA, S_END
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   tim_acc, tim_n;
  logic [RW-1:0]   reg_acc, reg_n;
  logic [HW-1:0]   pc_acc, pc_n;
  logic [HW-1:0]   addr_acc, addr_n;
  logic [HW-1:0]   data_acc, data_n;
  logic            is_mem, mem_n;
  logic            fire;
  logic [3:0]      err_nxt;

  logic            is_dec, is_hex, is_sp;
  logic [3:0]      nib;

  always_comb begin
    is_dec = (char >= 8'h30) && (char <= 8'h39);
    is_sp  = (char == 8'h20);
    is_hex = 1'b0;
    nib    = '0;
    if (is_dec) begin
      is_hex = 1'b1;
      nib    = char[3:0];
    end else if (((char >= 8'h61) && (char <= 8'h66)) || ((char >= 8'h41) && (char <= 8'h46))) begin
      // 'a'..'f' and 'A'..'F' both carry 1..6 in the low nibble
      is_hex = 1'b1;
      nib    = char[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tim_n   = tim_acc;
    reg_n   = reg_acc;
    pc_n    = pc_acc;
    addr_n  = addr_acc;
    data_n  = data_acc;
    mem_n   = is_mem;
    fire    = 1'b0;
    if (char == 8'h5E) begin
      state_n = S_TIME;
      cnt_n   = '0;
      tim_n   = '0;
      reg_n   = '0;
      pc_n    = '0;
      addr_n  = '0;
      data_n  = '0;
      mem_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_TIME: begin
          if (is_dec && (cnt < CW'(TIME_DIG))) begin
            tim_n = tim_acc * TW'(10) + TW'(nib);
            cnt_n = cnt + CW'(1);
          end else if ((char == 8'h40) && (cnt != '0)) begin
            state_n = S_PC;
            cnt_n   = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_PC: begin
          if (is_hex) begin
            pc_n = (pc_acc << 4) | HW'(nib);
            if (cnt == CW'(HEX_DIG - 1)) begin
              state_n = S_COLON;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        S_COLON: state_n = (char == 8'h3A) ? S_SEL : S_IDLE;
        S_SEL: begin
          cnt_n = '0;
          if (char == 8'h24) begin
            state_n = S_REG;
            mem_n   = 1'b0;
          end else if (char == 8'h2A) begin
            state_n = S_ADDR;
            mem_n   = 1'b1;
          end else if (!is_sp) begin
            state_n = S_IDLE;
          end
        end
        S_REG: begin
          if (is_dec && (cnt < CW'(REG_DIG))) begin
            reg_n = reg_acc * RW'(10) + RW'(nib);
            cnt_n = cnt + CW'(1);
          end else if (is_sp && (cnt != '0)) begin
            state_n = S_LT;
          end else if ((char == 8'h3C) && (cnt != '0)) begin
            state_n = S_EQ;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_ADDR: begin
          if (is_hex) begin
            addr_n = (addr_acc << 4) | HW'(nib);
            if (cnt == CW'(HEX_DIG - 1)) begin
              state_n = S_LT;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        S_LT: begin
          if (char == 8'h3C) state_n = S_EQ;
          else if (!is_sp)   state_n = S_IDLE;
        end
        S_EQ: begin
          cnt_n   = '0;
          state_n = (char == 8'h3D) ? S_DATA : S_IDLE;
        end
        S_DATA: begin
          // leading spaces are only legal before the first data digit
          if (is_hex) begin
            data_n = (data_acc << 4) | HW'(nib);
            if (cnt == CW'(HEX_DIG - 1)) begin
              state_n = S_END;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else if (!(is_sp && (cnt == '0))) begin
            state_n = S_IDLE;
          end
        end
        S_END: begin
          if (char == 8'h23) begin
            fire    = 1'b1;
            state_n = S_IDLE;
          end else if (!is_sp) begin
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

`ifdef CPU_TRACE_CHECK_ERR_EN
  logic [XW-1:0] tim_x, half_x, pc_x, addr_x, reg_x;

  assign tim_x  = XW'(tim_acc);
  assign half_x = XW'(freq >> 1);
  assign pc_x   = XW'(pc_acc);
  assign addr_x = XW'(addr_acc);
  assign reg_x  = XW'(reg_acc);

  always_comb begin
    err_nxt    = '0;
    err_nxt[0] = (half_x != '0) && ((tim_x % half_x) != '0);
    err_nxt[1] = (pc_x < XW'(PC_LO)) || (pc_x > XW'(PC_HI)) || (pc_acc[1:0] != 2'b00);
    err_nxt[2] = is_mem && ((addr_x > XW'(ADDR_HI)) || (addr_acc[1:0] != 2'b00));
    err_nxt[3] = !is_mem && (reg_x > XW'(31));
  end
`else
  assign err_nxt = '0;
`endif

  // data is parsed for well-formedness only; no check consumes its value
  logic unused_bits;
  assign unused_bits = ^{data_acc, freq, tim_acc, reg_acc, pc_acc, addr_acc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tim_acc     <= '0;
      reg_acc     <= '0;
      pc_acc      <= '0;
      addr_acc    <= '0;
      data_acc    <= '0;
      is_mem      <= 1'b0;
      format_type <= '0;
      error_code  <= '0;
      line_count  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tim_acc  <= tim_n;
      reg_acc  <= reg_n;
      pc_acc   <= pc_n;
      addr_acc <= addr_n;
      data_acc <= data_n;
      is_mem   <= mem_n;
      if (fire) begin
        format_type <= is_mem ? 2'd2 : 2'd1;
        error_code  <= err_nxt;
        line_count  <= line_count + 16'd1;
      end else begin
        format_type <= '0;
        error_code  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Self-checking bench for cpu_trace_checker: directed vector table, reset sequences,
// and random trace lines scored against a string-parsing reference model.
module tb_cpu_trace_checker;

  localparam int unsigned TIME_DIG = 4;
  localparam int unsigned REG_DIG  = 4;
  localparam int unsigned HEX_DIG  = 8;
  localparam logic [31:0] PC_LO    = 32'h3000;
  localparam logic [31:0] PC_HI    = 32'h4fff;
  localparam logic [31:0] ADDR_HI  = 32'h2fff;

`ifdef CPU_TRACE_CHECK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic [15:0] line_count;

  int tests     = 0;
  int fails     = 0;
  int exp_lines = 0;

  always #5 clk = ~clk;

  cpu_trace_checker #(
    .TIME_DIG(TIME_DIG), .REG_DIG(REG_DIG), .HEX_DIG(HEX_DIG),
    .PC_LO(PC_LO), .PC_HI(PC_HI), .ADDR_HI(ADDR_HI)
  ) dut (
    .clk(clk), .reset(reset), .char(char), .freq(freq),
    .format_type(format_type), .error_code(error_code), .line_count(line_count)
  );

  typedef struct {
    string       line;
    logic [15:0] freq;
    logic [1:0]  ft;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_chars(input string s);
    for (int i = 0; i < s.len(); i++) begin
      char = s.getc(i);
      @(negedge clk);
    end
  endtask

  // Feeds one line with no gap before it; expects a single pulse right after the last char.
  task automatic run_line(input string s, input logic [1:0] eft, input logic [3:0] eerr,
                          input string name);
    int stray = 0;
    for (int i = 0; i < s.len(); i++) begin
      char = s.getc(i);
      @(negedge clk);
      if ((i < s.len() - 1) && (format_type != 2'd0)) stray++;
    end
    if (eft != 2'd0) exp_lines = (exp_lines + 1) % 65536;
    chk({name, ".stray_pulse"}, 16'(stray), 16'd0);
    chk({name, ".format_type"}, 16'(format_type), 16'(eft));
    chk({name, ".error_code"}, 16'(error_code), ERR_EN ? 16'(eerr) : 16'd0);
    chk({name, ".line_count"}, line_count, 16'(exp_lines));
  endtask

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Whole-line grammar parser; yields the outcome a checker must report for this line.
  function automatic void ref_model(input string s, input logic [15:0] f,
                                    output logic [1:0] ft, output logic [3:0] err);
    int p, n, cnt;
    longint tv, pcv, rv, av, half;
    bit mem;
    ft = 2'd0; err = 4'd0; n = s.len();
    tv = 0; pcv = 0; rv = 0; av = 0; mem = 1'b0;
    if (n < 2 || s.getc(0) != "^") return;
    p = 1; cnt = 0;
    while (p < n && hexval(s.getc(p)) >= 0 && hexval(s.getc(p)) < 10) begin
      tv = tv * 10 + hexval(s.getc(p)); cnt++; p++;
    end
    if (cnt < 1 || cnt > int'(TIME_DIG)) return;
    if (p >= n || s.getc(p) != "@") return;
    p++; cnt = 0;
    while (p < n && hexval(s.getc(p)) >= 0) begin
      pcv = pcv * 16 + hexval(s.getc(p)); cnt++; p++;
    end
    if (cnt != int'(HEX_DIG)) return;
    if (p >= n || s.getc(p) != ":") return;
    p++;
    while (p < n && s.getc(p) == " ") p++;
    if (p >= n) return;
    cnt = 0;
    if (s.getc(p) == "$") begin
      p++;
      while (p < n && hexval(s.getc(p)) >= 0 && hexval(s.getc(p)) < 10) begin
        rv = rv * 10 + hexval(s.getc(p)); cnt++; p++;
      end
      if (cnt < 1 || cnt > int'(REG_DIG)) return;
    end else if (s.getc(p) == "*") begin
      mem = 1'b1; p++;
      while (p < n && hexval(s.getc(p)) >= 0) begin
        av = av * 16 + hexval(s.getc(p)); cnt++; p++;
      end
      if (cnt != int'(HEX_DIG)) return;
    end else begin
      return;
    end
    while (p < n && s.getc(p) == " ") p++;
    if (p + 1 >= n || s.getc(p) != "<" || s.getc(p + 1) != "=") return;
    p += 2;
    while (p < n && s.getc(p) == " ") p++;
    cnt = 0;
    while (p < n && hexval(s.getc(p)) >= 0) begin cnt++; p++; end
    if (cnt != int'(HEX_DIG)) return;
    while (p < n && s.getc(p) == " ") p++;
    if (p != n - 1 || s.getc(p) != "#") return;
    ft   = mem ? 2'd2 : 2'd1;
    half = longint'(f) / 2;
    if (half != 0 && (tv % half) != 0) err[0] = 1'b1;
    if (pcv < longint'(PC_LO) || pcv > longint'(PC_HI) || (pcv % 4) != 0) err[1] = 1'b1;
    if (mem && (av > longint'(ADDR_HI) || (av % 4) != 0)) err[2] = 1'b1;
    if (!mem && rv > 31) err[3] = 1'b1;
  endfunction

  function automatic string dec_str(input int n);
    string s = "";
    for (int k = 0; k < n; k++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
    return s;
  endfunction

  function automatic string hex_str(input logic [31:0] v, input int n);
    string s = "";
    string c;
    logic [3:0] nb;
    for (int k = n - 1; k >= 0; k--) begin
      nb = (k < 8) ? v[4*k +: 4] : 4'($urandom_range(0, 15));
      c  = $sformatf("%h", nb);
      if ($urandom_range(0, 1) == 1) c = c.toupper();
      s = {s, c};
    end
    return s;
  endfunction

  function automatic string sp_str();
    string s = "";
    int n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) s = {s, " "};
    return s;
  endfunction

  function automatic int hex_len();
    int r = $urandom_range(0, 19);
    if (r == 0) return HEX_DIG - 1;
    if (r == 1) return HEX_DIG + 1;
    return HEX_DIG;
  endfunction

  function automatic string gen_line();
    string t, fld, s, cset;
    logic [31:0] pcv, av;
    int r, nd, pos;
    r  = $urandom_range(0, 9);
    nd = (r == 0) ? 0 : (r == 1) ? TIME_DIG + 1 : $urandom_range(1, TIME_DIG);
    t  = dec_str(nd);
    case ($urandom_range(0, 4))
      0:       pcv = PC_LO + ($urandom_range(0, PC_HI - PC_LO) & ~32'h3);
      1:       pcv = PC_LO + $urandom_range(0, PC_HI - PC_LO);
      2:       pcv = $urandom;
      3:       pcv = PC_LO - 32'd4;
      default: pcv = PC_HI - 32'd3;
    endcase
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 4))
        0:       av = $urandom_range(0, ADDR_HI) & ~32'h3;
        1:       av = $urandom_range(0, ADDR_HI);
        2:       av = ADDR_HI + 32'd1;
        3:       av = ADDR_HI - 32'd3;
        default: av = $urandom;
      endcase
      fld = {"*", hex_str(av, hex_len())};
    end else begin
      r = $urandom_range(0, 9);
      if (r == 0)      fld = "$";
      else if (r == 1) fld = {"$", dec_str(REG_DIG + 1)};
      else             fld = $sformatf("$%0d", $urandom_range(0, 63));
    end
    s = {"^", t, "@", hex_str(pcv, hex_len()), ":", sp_str(), fld, sp_str(), "<=",
         sp_str(), hex_str($urandom, hex_len()), sp_str(), "#"};
    if ($urandom_range(0, 4) == 0) begin
      cset = "x:@<= 0aZ";
      pos  = $urandom_range(1, s.len() - 2);
      s.putc(pos, cset.getc($urandom_range(0, cset.len() - 1)));
    end
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string       s;
    logic [1:0]  eft;
    logic [3:0]  eerr;
    logic [15:0] fsel [8];

    vecs[0]  = '{"^242@000030f4: $31 <= 12345678#",          16'd2, 2'd1, 4'h0};
    vecs[1]  = '{"^338@00003130: *00000088 <= Ffffb528#",    16'd2, 2'd2, 4'h0};
    vecs[2]  = '{"^338@00003130: *00000088 <= ffffb52812#",  16'd2, 2'd0, 4'h0};
    vecs[3]  = '{"^242@000030f4: $31 <=   ab123215 #",       16'd2, 2'd1, 4'h0};
    vecs[4]  = '{"^243@00002002: $40 <= 00000000#",          16'd4, 2'd1, 4'hB};
    vecs[5]  = '{"^12345@000030f4: $1 <= 00000000#",         16'd2, 2'd0, 4'h0};
    vecs[6]  = '{"^@000030f4: $1 <= 00000000#",              16'd2, 2'd0, 4'h0};
    vecs[7]  = '{"^9999@00004fff: *00003000 <= 00000000#",   16'd2, 2'd2, 4'h6};
    vecs[8]  = '{"^1@00004ffc:*00002ffc<=DEADBEEF#",         16'd0, 2'd2, 4'h0};
    vecs[9]  = '{"^7@00003000: $0 <= 0000000#",              16'd2, 2'd0, 4'h0};
    vecs[10] = '{"^1@0000^5@00003000: $5 <= 00000000#",      16'd3, 2'd1, 4'h0};
    vecs[11] = '{"^6@00003000: $12345 <= 00000000#",         16'd2, 2'd0, 4'h0};
    vecs[12] = '{"^6@00003001: $32 <= 00000000#",            16'd8, 2'd1, 4'hB};

    fsel[0] = 16'd0; fsel[1] = 16'd1; fsel[2] = 16'd2; fsel[3] = 16'd4;
    fsel[4] = 16'd6; fsel[5] = 16'd8; fsel[6] = 16'd14; fsel[7] = 16'd20;

    reset = 1'b0;
    char  = " ";
    freq  = 16'd2;
    repeat (2) @(negedge clk);
    chk("reset.format_type", 16'(format_type), 16'd0);
    chk("reset.error_code", 16'(error_code), 16'd0);
    chk("reset.line_count", line_count, 16'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      freq = vecs[i].freq;
      run_line(vecs[i].line, vecs[i].ft, vecs[i].err, $sformatf("vec%0d", i));
    end
    char = " ";
    @(negedge clk);
    chk("pulse_ends.format_type", 16'(format_type), 16'd0);

    freq = 16'd2;
    drive_chars("^242@000030f4: $31 <= 1234");
    #2 reset = 1'b0;
    #1;
    chk("async_reset.line_count", line_count, 16'd0);
    chk("async_reset.format_type", 16'(format_type), 16'd0);
    exp_lines = 0;
    @(negedge clk) char = "5";
    @(negedge clk) char = "6";
    @(negedge clk);
    chk("held_reset.line_count", line_count, 16'd0);
    chk("held_reset.error_code", 16'(error_code), 16'd0);
    reset = 1'b1;
    run_line("78#", 2'd0, 4'h0, "post_reset_tail");
    run_line(vecs[0].line, 2'd1, 4'h0, "post_reset_line");

    for (int n = 0; n < 150; n++) begin
      s    = gen_line();
      freq = fsel[$urandom_range(0, 7)];
      ref_model(s, freq, eft, eerr);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        char = ($urandom_range(0, 1) == 1) ? "x" : " ";
        @(negedge clk);
      end
      run_line(s, eft, eerr, $sformatf("rand%0d", n));
    end

    char = " ";
    @(negedge clk);
    chk("final_idle.format_type", 16'(format_type), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
